apb_vgachargen_ctrl: RTL and testbench

//   APB4 completer that sits in front of the VGA text-mode generator and is the writer/reader of its

---
 rtl/vgachargen_pkg.sv | 25 ++
 rtl/apb_vgachargen_decode.sv | 36 +++
 rtl/apb_vgachargen_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_apb_vgachargen_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vgachargen_pkg.sv
// Shared definitions for the APB front end of the VGA text-mode generator.
// Holds the default screen geometry, the APB window bases, the controller
// state encoding and the colour-cell layout.
package vgachargen_pkg;

  localparam int unsigned CELLS_DEF    = 2400;          // 80x30 text cells
  localparam logic [31:0] CH_BASE_DEF  = 32'h0000_0000; // character-map window
  localparam logic [31:0] COL_BASE_DEF = 32'h0000_1000; // colour-map window
  localparam int unsigned CELL_AW      = $clog2(CELLS_DEF);

  typedef enum logic [2:0] {
    IDLE,
    LANE,
    CAPT,
    RESP,
    ERR
  } state_e;

  // One colour-map cell: background in the upper nibble, foreground below.
  typedef struct packed {
    logic [3:0] bg;
    logic [3:0] fg;
  } col_byte_t;

endpackage

// File: rtl/apb_vgachargen_decode.sv
// Combinational APB window decode for apb_vgachargen_ctrl.
// Ports:
//   addr     in   32       APB byte address
//   valid    out  1        address falls inside one of the two windows
//   sel_col  out  1        1 = colour-map window, 0 = character-map window
//   word     out  AW-2     word index inside the selected window
module apb_vgachargen_decode #(
  parameter int unsigned CELLS    = 2400,
  parameter logic [31:0] CH_BASE  = 32'h0000_0000,
  parameter logic [31:0] COL_BASE = 32'h0000_1000,
  parameter int unsigned AW       = 12
) (
  input  logic [31:0]   addr,
  output logic          valid,
  output logic          sel_col,
  output logic [AW-3:0] word
);

  logic [31:0] ch_off;
  logic [31:0] col_off;
  logic        in_ch;
  logic        in_col;

  always_comb begin
    ch_off  = addr - CH_BASE;
    col_off = addr - COL_BASE;
    // Lower bound guards against the subtraction wrapping below the base.
    in_ch   = (addr >= CH_BASE)  && (ch_off  < 32'(CELLS));
    in_col  = (addr >= COL_BASE) && (col_off < 32'(CELLS));
    valid   = in_ch || in_col;
    // Character map wins if the two windows were ever configured to overlap.
    sel_col = in_col && !in_ch;
    word    = sel_col ? col_off[AW-1:2] : ch_off[AW-1:2];
  end

endmodule

// File: rtl/apb_vgachargen_ctrl.sv
// APB4 completer owning the character and colour maps of the VGA text
// generator. One 32-bit APB word covers four consecutive cells; each access
// is serialised into four 8-bit map accesses, one per byte lane.
// Optional feature macro: VGACHARGEN_APB_READ_EN (map read-back). Without it,
// reads to valid addresses complete immediately with zero data.
// Ports:
//   clk_i, rst_i                      clock, async active-high reset
//   psel_i, penable_i, pwrite_i       APB control
//   paddr_i, pwdata_i, pstrb_i        APB address / write data / strobes
//   prdata_o, pready_o, pslverr_o     APB response (registered)
//   ch_map_addr_o/data_o/wen_o        character-map write/read port
//   ch_map_data_i                     character-map read data (1-cycle)
//   col_map_addr_o/data_o/wen_o       colour-map write/read port
//   col_map_data_i                    colour-map read data (1-cycle)
module apb_vgachargen_ctrl
  import vgachargen_pkg::*;
#(
  parameter int unsigned CELLS    = CELLS_DEF,
  parameter logic [31:0] CH_BASE  = CH_BASE_DEF,
  parameter logic [31:0] COL_BASE = COL_BASE_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     psel_i,
  input  logic                     penable_i,
  input  logic                     pwrite_i,
  input  logic [31:0]              paddr_i,
  input  logic [31:0]              pwdata_i,
  input  logic [3:0]               pstrb_i,
  output logic [31:0]              prdata_o,
  output logic                     pready_o,
  output logic                     pslverr_o,
  output logic [$clog2(CELLS)-1:0] ch_map_addr_o,
  output logic [7:0]               ch_map_data_o,
  output logic                     ch_map_wen_o,
  input  logic [7:0]               ch_map_data_i,
  output logic [$clog2(CELLS)-1:0] col_map_addr_o,
  output logic [7:0]               col_map_data_o,
  output logic                     col_map_wen_o,
  input  logic [7:0]               col_map_data_i
);

  localparam int unsigned AW = $clog2(CELLS);

  logic          dec_valid;
  logic          dec_sel_col;
  logic [AW-3:0] dec_word;

  apb_vgachargen_decode #(
    .CELLS    (CELLS),
    .CH_BASE  (CH_BASE),
    .COL_BASE (COL_BASE),
    .AW       (AW)
  ) u_decode (
    .addr    (paddr_i),
    .valid   (dec_valid),
    .sel_col (dec_sel_col),
    .word    (dec_word)
  );

  state_e        state_q, state_d;
  logic [1:0]    lane_q, lane_d;
  logic          wr_q, wr_d;
  logic          col_q, col_d;
  logic [AW-3:0] word_q, word_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    strb_q, strb_d;

  logic [AW-1:0] ch_addr_q, ch_addr_d, col_addr_q, col_addr_d;
  logic [7:0]    ch_data_q, ch_data_d, col_data_q, col_data_d;
  logic          ch_wen_q, ch_wen_d, col_wen_q, col_wen_d;
  logic          pready_q, pready_d, pslverr_q, pslverr_d;
  logic [31:0]   prdata_q, prdata_d;

  // Lane driver: selects which latched (or freshly sampled) request a lane
  // access is built from.
  logic          drv_en, drv_wr, drv_col;
  logic [1:0]    drv_lane;
  logic [AW-3:0] drv_word;
  logic [31:0]   drv_wdata;
  logic [3:0]    drv_strb;

`ifdef VGACHARGEN_APB_READ_EN
  logic [15:0] rd_q, rd_d;   // lanes 0 and 1 of the read word
  logic [7:0]  rd_byte;
  assign rd_byte = col_q ? col_map_data_i : ch_map_data_i;
`else
  logic unused_rd;
  assign unused_rd = ^{ch_map_data_i, col_map_data_i};
`endif

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    wr_d       = wr_q;
    col_d      = col_q;
    word_d     = word_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    ch_addr_d  = '0;
    ch_data_d  = '0;
    ch_wen_d   = 1'b0;
    col_addr_d = '0;
    col_data_d = '0;
    col_wen_d  = 1'b0;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    prdata_d   = '0;
    drv_en     = 1'b0;
    drv_lane   = '0;
    drv_wr     = wr_q;
    drv_col    = col_q;
    drv_word   = word_q;
    drv_wdata  = wdata_q;
    drv_strb   = strb_q;
`ifdef VGACHARGEN_APB_READ_EN
    rd_d       = rd_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (psel_i && penable_i) begin
          wr_d    = pwrite_i;
          col_d   = dec_sel_col;
          word_d  = dec_word;
          wdata_d = pwdata_i;
          strb_d  = pstrb_i;
          lane_d  = '0;
          if (!dec_valid) begin
            state_d   = ERR;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
`ifndef VGACHARGEN_APB_READ_EN
          end else if (!pwrite_i) begin
            state_d  = RESP;
            pready_d = 1'b1;
`endif
          end else begin
            // Lane 0 is issued straight from the APB inputs so it is
            // visible on the map port in the very next cycle.
            state_d   = LANE;
            drv_en    = 1'b1;
            drv_wr    = pwrite_i;
            drv_col   = dec_sel_col;
            drv_word  = dec_word;
            drv_wdata = pwdata_i;
            drv_strb  = pstrb_i;
          end
        end
      end
      LANE: begin
`ifdef VGACHARGEN_APB_READ_EN
        // Data seen now belongs to the lane issued one cycle earlier.
        case (lane_q)
          2'd1:    rd_d[7:0]  = rd_byte;
          2'd2:    rd_d[15:8] = rd_byte;
          default: ;
        endcase
`endif
        if (lane_q == 2'd3) begin
          state_d  = wr_q ? RESP : CAPT;
          pready_d = 1'b1;
`ifdef VGACHARGEN_APB_READ_EN
          prdata_d = wr_q ? '0 : {8'h00, rd_byte, rd_q};
`endif
        end else begin
          lane_d   = lane_q + 2'd1;
          drv_en   = 1'b1;
          drv_lane = lane_q + 2'd1;
        end
      end
      CAPT, RESP, ERR: state_d = IDLE;
      default:         state_d = IDLE;
    endcase

    if (drv_en) begin
      if (drv_col) begin
        col_addr_d = {drv_word, drv_lane};
        col_data_d = drv_wr ? 8'(drv_wdata >> {drv_lane, 3'b000}) : '0;
        col_wen_d  = drv_wr && drv_strb[drv_lane];
      end else begin
        ch_addr_d  = {drv_word, drv_lane};
        ch_data_d  = drv_wr ? 8'(drv_wdata >> {drv_lane, 3'b000}) : '0;
        ch_wen_d   = drv_wr && drv_strb[drv_lane];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      wr_q       <= 1'b0;
      col_q      <= 1'b0;
      word_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      ch_addr_q  <= '0;
      ch_data_q  <= '0;
      ch_wen_q   <= 1'b0;
      col_addr_q <= '0;
      col_data_q <= '0;
      col_wen_q  <= 1'b0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
`ifdef VGACHARGEN_APB_READ_EN
      rd_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      wr_q       <= wr_d;
      col_q      <= col_d;
      word_q     <= word_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      ch_addr_q  <= ch_addr_d;
      ch_data_q  <= ch_data_d;
      ch_wen_q   <= ch_wen_d;
      col_addr_q <= col_addr_d;
      col_data_q <= col_data_d;
      col_wen_q  <= col_wen_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      prdata_q   <= prdata_d;
`ifdef VGACHARGEN_APB_READ_EN
      rd_q       <= rd_d;
`endif
    end
  end

  assign ch_map_addr_o  = ch_addr_q;
  assign ch_map_data_o  = ch_data_q;
  assign ch_map_wen_o   = ch_wen_q;
  assign col_map_addr_o = col_addr_q;
  assign col_map_data_o = col_data_q;
  assign col_map_wen_o  = col_wen_q;
  assign pready_o       = pready_q;
  assign pslverr_o      = pslverr_q;

`ifdef VGACHARGEN_APB_READ_EN
  // Lane 3 is addressed in the last LANE cycle, so its byte only arrives in
  // the response cycle itself; it is merged into the registered lanes here so
  // the response needs no extra cycle.
  assign prdata_o = (state_q == CAPT) ? {rd_byte, prdata_q[23:0]} : prdata_q;
`else
  assign prdata_o = prdata_q;
`endif

endmodule

// File: tb/tb_apb_vgachargen_ctrl.sv
// Directed self-checking bench for apb_vgachargen_ctrl (default geometry).
module tb_apb_vgachargen_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_clr = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [11:0] ch_addr, col_addr;
  logic [7:0]  ch_wdat, col_wdat, ch_rdat, col_rdat;
  logic        ch_wen, col_wen;

  apb_vgachargen_ctrl #(
    .CELLS    (2400),
    .CH_BASE  (32'h0000_0000),
    .COL_BASE (32'h0000_1000)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .psel_i         (psel),
    .penable_i      (penable),
    .pwrite_i       (pwrite),
    .paddr_i        (paddr),
    .pwdata_i       (pwdata),
    .pstrb_i        (pstrb),
    .prdata_o       (prdata),
    .pready_o       (pready),
    .pslverr_o      (pslverr),
    .ch_map_addr_o  (ch_addr),
    .ch_map_data_o  (ch_wdat),
    .ch_map_wen_o   (ch_wen),
    .ch_map_data_i  (ch_rdat),
    .col_map_addr_o (col_addr),
    .col_map_data_o (col_wdat),
    .col_map_wen_o  (col_wen),
    .col_map_data_i (col_rdat)
  );

  always #5 clk = ~clk;

  // Map models: synchronous RAMs with one cycle of read latency.
  logic [7:0] ch_mem  [0:4095];
  logic [7:0] col_mem [0:4095];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) begin
        ch_mem[i]  <= '0;
        col_mem[i] <= '0;
      end
      ch_rdat  <= '0;
      col_rdat <= '0;
    end else begin
      ch_rdat  <= ch_mem[ch_addr];
      col_rdat <= col_mem[col_addr];
      if (ch_wen)  ch_mem[ch_addr]   <= ch_wdat;
      if (col_wen) col_mem[col_addr] <= col_wdat;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write-enable log (address, data, access-cycle index) and activity counts.
  int          a1 = 0;
  int          ch_n, col_n, ch_act, col_act;
  logic [11:0] ch_la [0:15];
  logic [7:0]  ch_ld [0:15];
  int          ch_lc [0:15];
  logic [11:0] col_la [0:15];
  logic [7:0]  col_ld [0:15];
  int          col_lc [0:15];

  always @(negedge clk) begin
    if (ch_wen && ch_n < 16) begin
      ch_la[ch_n] = ch_addr; ch_ld[ch_n] = ch_wdat; ch_lc[ch_n] = cyc - a1 + 1;
    end
    if (ch_wen) ch_n = ch_n + 1;
    if (col_wen && col_n < 16) begin
      col_la[col_n] = col_addr; col_ld[col_n] = col_wdat; col_lc[col_n] = cyc - a1 + 1;
    end
    if (col_wen) col_n = col_n + 1;
    if (ch_wen || (|ch_addr) || (|ch_wdat))     ch_act = ch_act + 1;
    if (col_wen || (|col_addr) || (|col_wdat)) col_act = col_act + 1;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    ch_n = 0; col_n = 0; ch_act = 0; col_act = 0;
  endtask

  // One APB transfer; lat is the access-cycle index (A1 = 1) of pready.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output int lat,
                          output logic [31:0] rdata, output logic err);
    int n;
    clear_log();
    lat = 0; rdata = '0; err = 1'b0; n = 1;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    a1 = cyc;
    while (lat == 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (pready) begin
        lat = n; rdata = prdata; err = pslverr;
      end
    end
    if (lat == 0) check_eq("pready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    check_eq("pready_one_cycle", {31'd0, pready}, 32'd0);
    psel = 1'b0; penable = 1'b0;
  endtask

  int          lat;
  logic [31:0] rd;
  logic        err;

  initial begin
    clear_log();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_pready",  {31'd0, pready}, 32'd0);
    check_eq("rst_pslverr", {31'd0, pslverr}, 32'd0);
    check_eq("rst_prdata",  prdata, 32'd0);
    check_eq("rst_ch_port", {11'd0, ch_wen, ch_addr, ch_wdat}, 32'd0);
    check_eq("rst_col_port", {11'd0, col_wen, col_addr, col_wdat}, 32'd0);
    rst = 1'b0; mem_clr = 1'b0;

    // Full-strobe write to char map word 4 -> cells 16..19.
    apb_xfer(1'b1, 32'h10, 32'h4443_4241, 4'hF, lat, rd, err);
    check_eq("wr10_lat", lat, 32'd6);
    check_eq("wr10_err", {31'd0, err}, 32'd0);
    check_eq("wr10_ch_wens", ch_n, 32'd4);
    check_eq("wr10_col_act", col_act, 32'd0);
    for (int k = 0; k < 4; k++) begin
      check_eq("wr10_addr", {20'd0, ch_la[k]}, 32'(16 + k));
      check_eq("wr10_data", {24'd0, ch_ld[k]}, 32'(8'h41 + k));
      check_eq("wr10_cycle", ch_lc[k], 32'(2 + k));
    end

    // Single-lane colour write.
    apb_xfer(1'b1, 32'h1000, 32'h0000_00F0, 4'b0001, lat, rd, err);
    check_eq("wr1000_lat", lat, 32'd6);
    check_eq("wr1000_col_wens", col_n, 32'd1);
    check_eq("wr1000_addr", {20'd0, col_la[0]}, 32'd0);
    check_eq("wr1000_data", {24'd0, col_ld[0]}, 32'hF0);
    check_eq("wr1000_cycle", col_lc[0], 32'd2);
    check_eq("wr1000_ch_act", ch_act, 32'd0);

    // Zero-strobe write: full sequence, no enables, OKAY.
    apb_xfer(1'b1, 32'h14, 32'hFFFF_FFFF, 4'h0, lat, rd, err);
    check_eq("strb0_lat", lat, 32'd6);
    check_eq("strb0_err", {31'd0, err}, 32'd0);
    check_eq("strb0_wens", ch_n + col_n, 32'd0);

    // Last valid word of the char window: cells 2396..2399.
    apb_xfer(1'b1, 32'h95C, 32'h0403_0201, 4'hF, lat, rd, err);
    check_eq("last_lat", lat, 32'd6);
    check_eq("last_wens", ch_n, 32'd4);
    check_eq("last_addr", {20'd0, ch_la[3]}, 32'd2399);

    // Out-of-window accesses.
    apb_xfer(1'b1, 32'h960, 32'h1234_5678, 4'hF, lat, rd, err);
    check_eq("err960_lat", lat, 32'd2);
    check_eq("err960_slverr", {31'd0, err}, 32'd1);
    check_eq("err960_prdata", rd, 32'd0);
    check_eq("err960_act", ch_act + col_act, 32'd0);
    apb_xfer(1'b0, 32'h2000, 32'h0, 4'h0, lat, rd, err);
    check_eq("err2000_lat", lat, 32'd2);
    check_eq("err2000_slverr", {31'd0, err}, 32'd1);
    check_eq("err2000_prdata", rd, 32'd0);
    check_eq("err2000_act", ch_act + col_act, 32'd0);

    // Reset asserted in A3 of a write: only lane 0 (cell 32) lands.
    clear_log();
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20;
    pwdata = 32'h8877_6655; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1; a1 = cyc;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("rstmid_ch_port", {11'd0, ch_wen, ch_addr, ch_wdat}, 32'd0);
    @(posedge clk); #1;
    check_eq("rstmid_outputs", {29'd0, pready, pslverr, ch_wen}, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("rstmid_wens", ch_n, 32'd1);
    check_eq("rstmid_addr", {20'd0, ch_la[0]}, 32'd32);
    check_eq("rstmid_data", {24'd0, ch_ld[0]}, 32'h55);

    apb_xfer(1'b1, 32'h24, 32'hDDCC_BBAA, 4'hF, lat, rd, err);
    check_eq("post_rst_lat", lat, 32'd6);
    check_eq("post_rst_wens", ch_n, 32'd4);
    check_eq("post_rst_addr0", {20'd0, ch_la[0]}, 32'd36);
    check_eq("post_rst_data3", {24'd0, ch_ld[3]}, 32'hDD);

`ifdef VGACHARGEN_APB_READ_EN
    apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, err);
    check_eq("rd10_lat", lat, 32'd6);
    check_eq("rd10_data", rd, 32'h4443_4241);
    check_eq("rd10_err", {31'd0, err}, 32'd0);
    check_eq("rd10_wens", ch_n + col_n, 32'd0);
    check_eq("rd10_col_act", col_act, 32'd0);
    apb_xfer(1'b0, 32'h1000, 32'h0, 4'hF, lat, rd, err);
    check_eq("rd1000_data", rd, 32'h0000_00F0);
    check_eq("rd1000_ch_act", ch_act, 32'd0);
    apb_xfer(1'b0, 32'h20, 32'h0, 4'h0, lat, rd, err);
    check_eq("rd20_data", rd, 32'h0000_0055);
    apb_xfer(1'b0, 32'h24, 32'h0, 4'h0, lat, rd, err);
    check_eq("rd24_data", rd, 32'hDDCC_BBAA);
    apb_xfer(1'b0, 32'h14, 32'h0, 4'h0, lat, rd, err);
    check_eq("rd14_data", rd, 32'h0);
`else
    apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, err);
    check_eq("rd10_lat", lat, 32'd2);
    check_eq("rd10_data", rd, 32'h0);
    check_eq("rd10_err", {31'd0, err}, 32'd0);
    check_eq("rd10_act", ch_act + col_act, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
